// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
//  - tx_state_t : transmitter FSM states
//  - CMD_*      : common PS/2 command bytes, ACK_BYTE is the device reply
//  - LAST_EDGE  : falling-edge count at which the device ACK is sampled
//  - odd_parity : PS/2 parity bit for a data byte
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_XFER,
    ST_ACK,
    ST_WAITIDLE,
    ST_DONE,
    ST_ERR
  } tx_state_t;

  localparam logic [7:0] CMD_SETLED = 8'hED;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] ACK_BYTE   = 8'hFA;

  localparam logic [3:0] STOP_EDGE  = 4'd10;
  localparam logic [3:0] LAST_EDGE  = 4'd11;

  // Odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser and debounce filter for one raw PS/2 pad line.
//  clk     in  system clock
//  rst     in  synchronous active-high reset (line assumed idle-high)
//  line_in in  raw asynchronous pad level
//  level   out filtered level; changes after FILTER equal synchronised samples
//  fall    out one-cycle pulse in the cycle level goes 1 -> 0
module ps2_line_filter #(
  parameter int unsigned FILTER = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int unsigned FW = $clog2(FILTER + 1);

  logic [1:0]    sync;
  logic [FW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '1;
      cnt   <= '0;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], line_in};
      fall <= 1'b0;
      if (sync[1] != level) begin
        // cnt holds how many differing samples were already seen.
        if (cnt == FW'(FILTER - 1)) begin
          level <= sync[1];
          cnt   <= '0;
          fall  <= level;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to a keyboard or
// mouse, driving both lines open-drain through active-high pull-low enables.
//  clk, rst               system clock, synchronous active-high reset
//  ps2clk_in, ps2data_in  raw pad levels (asynchronous)
//  ps2clk_oe, ps2data_oe  1 = pull the line low
//  tx_data, tx_start      byte and one-cycle request (ignored while busy)
//  tx_busy                frame in flight
//  tx_done, tx_error      one-cycle completion / failure pulses
//  rx_inhibit             tells the co-located receiver to ignore the lines
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned CLKFREQ    = 28000000,
  parameter int unsigned INHIBIT_US = 120,
  parameter int unsigned TIMEOUT_MS = 15,
  parameter int unsigned FILTER     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit
);

  localparam int unsigned NI   = (CLKFREQ / 1000000) * INHIBIT_US;
  localparam int unsigned NR   = (CLKFREQ / 1000000) * 5;
  localparam int unsigned NT   = (CLKFREQ / 1000) * TIMEOUT_MS;
  localparam int unsigned NMAX = (NI > NR) ? NI : NR;
  localparam int unsigned CW   = $clog2(NMAX + 1);
  localparam int unsigned TW   = $clog2(NT + 1);

  tx_state_t     state;
  logic [8:0]    shreg;       // {parity, data}, shifted out LSB first
  logic [3:0]    edge_cnt;
  logic [3:0]    edge_next;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmr;
  logic          timing;

  logic clk_lvl, clk_fall;
  logic data_lvl, data_fall_unused;

  ps2_line_filter #(.FILTER(FILTER)) u_clk_filter (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2clk_in),
    .level   (clk_lvl),
    .fall    (clk_fall)
  );

  ps2_line_filter #(.FILTER(FILTER)) u_data_filter (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2data_in),
    .level   (data_lvl),
    .fall    (data_fall_unused)
  );

  assign edge_next  = (edge_cnt >= LAST_EDGE) ? LAST_EDGE : edge_cnt + 4'd1;
  assign timing     = (state == ST_XFER) || (state == ST_ACK) || (state == ST_WAITIDLE);
  assign rx_inhibit = tx_busy;

  // Completion and failure are registered on the transition into DONE/ERR,
  // so the pulse, the busy drop and the ignored tx_start share one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      edge_cnt   <= '0;
      cnt        <= '0;
      tmr        <= '0;
      ps2clk_oe  <= 1'b0;
      ps2data_oe <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (timing && tmr == '0) begin
        ps2clk_oe  <= 1'b0;
        ps2data_oe <= 1'b0;
        tx_busy    <= 1'b0;
        tx_error   <= 1'b1;
        state      <= ST_ERR;
      end else begin
        if (timing) tmr <= tmr - 1'b1;
        case (state)
          ST_IDLE: begin
            if (tx_start) begin
              shreg     <= {odd_parity(tx_data), tx_data};
              cnt       <= CW'(NI - 1);
              ps2clk_oe <= 1'b1;
              tx_busy   <= 1'b1;
              state     <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (cnt == '0) begin
              cnt        <= CW'(NR - 1);
              ps2data_oe <= 1'b1;   // start bit
              state      <= ST_REQ;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_REQ: begin
            if (cnt == '0) begin
              ps2clk_oe <= 1'b0;
              edge_cnt  <= '0;
              tmr       <= TW'(NT - 1);
              state     <= ST_XFER;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_XFER: begin
            // Falls 1..9 present data then parity; fall 10 presents stop.
            if (clk_fall) begin
              edge_cnt <= edge_next;
              if (edge_next == STOP_EDGE) begin
                ps2data_oe <= 1'b0;
                state      <= ST_ACK;
              end else begin
                ps2data_oe <= ~shreg[0];
                shreg      <= {1'b0, shreg[8:1]};
              end
            end
          end
          ST_ACK: begin
            if (clk_fall) begin
              edge_cnt <= edge_next;
              if (!data_lvl) begin
                state <= ST_WAITIDLE;
              end else begin
                ps2clk_oe  <= 1'b0;
                ps2data_oe <= 1'b0;
                tx_busy    <= 1'b0;
                tx_error   <= 1'b1;
                state      <= ST_ERR;
              end
            end
          end
          ST_WAITIDLE: begin
            if (clk_lvl && data_lvl) begin
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
              state   <= ST_DONE;
            end
          end
          ST_DONE, ST_ERR: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int CLKFREQ    = 1000000;
  localparam int INHIBIT_US = 120;
  localparam int TIMEOUT_MS = 2;
  localparam int FILTER     = 2;
  localparam int NI = CLKFREQ / 1000000 * INHIBIT_US;
  localparam int NR = CLKFREQ / 1000000 * 5;
  localparam int NT = CLKFREQ / 1000 * TIMEOUT_MS;

  logic clk = 1'b0;
  logic rst;
  logic ps2clk_oe, ps2data_oe;
  logic [7:0] tx_data;
  logic tx_start;
  logic tx_busy, tx_done, tx_error, rx_inhibit;
  logic dev_clk_low, dev_data_low;
  logic clk_line, data_line;

  // Open-drain bus: the line is low if either side pulls it.
  assign clk_line  = ~(ps2clk_oe | dev_clk_low);
  assign data_line = ~(ps2data_oe | dev_data_low);

  always #500 clk = ~clk;

  ps2_host_tx #(
    .CLKFREQ    (CLKFREQ),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_MS (TIMEOUT_MS),
    .FILTER     (FILTER)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2clk_in  (clk_line),
    .ps2data_in (data_line),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .rx_inhibit (rx_inhibit)
  );

  typedef struct {
    logic [7:0] data;
    logic       parity;
    logic       ok;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int pulses = 0;
  int dev_frames = 0;
  logic [7:0] dev_byte;
  logic dev_par, dev_stop, dev_start;
  bit seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference parity: the nine transmitted bits carry an odd count of ones.
  function automatic logic model_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // Device: waits for a request (clock released, data low), clocks 11 times
  // at 80 cycles per bit, reads data while clock is high, optionally ACKs.
  // abort_fall != 0 stops with the clock held low at that fall.
  task automatic device_serve(input bit do_ack, input int abort_fall, output bit found);
    found = 1'b0;
    dev_byte = 'x; dev_par = 1'bx; dev_stop = 1'bx; dev_start = 1'bx;
    for (int t = 0; t < 3000 && !found; t++) begin
      @(negedge clk);
      if (clk_line && !data_line) found = 1'b1;
    end
    if (!found) return;
    dev_start = data_line;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && do_ack) begin
        dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      if (i == abort_fall) begin
        repeat (6) @(negedge clk);
        return;
      end
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk);
      if (i <= 8) dev_byte[i-1] = data_line;
      else if (i == 9) dev_par = data_line;
      else if (i == 10) dev_stop = data_line;
      repeat (20) @(negedge clk);
      if (i == 11) dev_data_low = 1'b0;
    end
    dev_frames++;
  endtask

  task automatic start_tx(input logic [7:0] b, input logic ok, input bit push);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    if (push) begin
      exp_q.push_back('{data: b, parity: model_parity(b), ok: ok});
      pushed++;
    end
    chk("busy_after_start", tx_busy, 1);
    chk("inhibit_after_start", rx_inhibit, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (tx_busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_within_bound", tx_busy, 0);
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard monitor: every completion/failure pulse consumes one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_done && tx_error) chk("done_and_error_together", 1, 0);
      if (tx_done || tx_error) begin
        exp_t e;
        pulses++;
        chk("busy_low_at_pulse", tx_busy, 0);
        chk("inhibit_low_at_pulse", rx_inhibit, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("outcome_done", tx_done, e.ok);
          chk("outcome_error", tx_error, !e.ok);
          if (e.ok && tx_done) begin
            chk("dev_start_bit", dev_start, 0);
            chk("dev_byte", dev_byte, e.data);
            chk("dev_parity", dev_par, e.parity);
            chk("dev_stop_bit", dev_stop, 1);
          end
        end
      end
    end
  end

  initial begin
    #100_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ni, nr, n, t, frames0;
    logic [7:0] b;
    bit ack;
    rst = 1'b1; tx_start = 1'b0; tx_data = '0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_clk_oe", ps2clk_oe, 0);
    chk("rst_data_oe", ps2data_oe, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_error", tx_error, 0);
    chk("rst_inhibit", rx_inhibit, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1) SETLED: inhibit/request lengths, then a full acknowledged frame.
    start_tx(CMD_SETLED, 1'b1, 1'b1);
    ni = 0; nr = 0; t = 0;
    while (ps2clk_oe && t < 1000) begin
      if (ps2data_oe) nr++; else ni++;
      @(negedge clk);
      t++;
    end
    chk("inhibit_cycles", ni, NI);
    chk("request_cycles", nr, NR);
    device_serve(1'b1, 0, seen);
    chk("t1_request_seen", seen, 1);
    wait_idle();

    // 2) ENABLE: frame completes, lines released at idle.
    start_tx(CMD_ENABLE, 1'b1, 1'b1);
    device_serve(1'b1, 0, seen);
    chk("t2_request_seen", seen, 1);
    wait_idle();
    chk("t2_idle_clk_oe", ps2clk_oe, 0);
    chk("t2_idle_data_oe", ps2data_oe, 0);

    // 3) Device never clocks: error NR+NT cycles after the inhibit ends.
    start_tx(CMD_ENABLE, 1'b0, 1'b1);
    t = 0;
    while (!ps2data_oe && t < 300) begin
      @(negedge clk);
      t++;
    end
    n = 0;
    while (!tx_error && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", n, NR + NT);
    chk("t3_clk_released", ps2clk_oe, 0);
    chk("t3_data_released", ps2data_oe, 0);
    wait_idle();

    // 4) Missing ACK: error at fall 11.
    start_tx(8'hA5, 1'b0, 1'b1);
    device_serve(1'b0, 0, seen);
    chk("t4_request_seen", seen, 1);
    wait_idle();

    // 5) Second request mid-frame is ignored.
    frames0 = dev_frames;
    start_tx(8'h3C, 1'b1, 1'b1);
    fork
      device_serve(1'b1, 0, seen);
      begin
        repeat (400) @(negedge clk);
        tx_data  = 8'hC3;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    chk("t5_request_seen", seen, 1);
    wait_idle();
    repeat (200) @(negedge clk);
    chk("t5_no_second_frame", tx_busy, 0);
    chk("t5_frames", dev_frames - frames0, 1);

    // 6) Reset during fall 5, then a clean RESET command.
    start_tx(8'h5A, 1'b1, 1'b0);
    device_serve(1'b1, 5, seen);
    chk("t6_request_seen", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_clk_oe", ps2clk_oe, 0);
    chk("t6_data_oe", ps2data_oe, 0);
    chk("t6_busy", tx_busy, 0);
    rst = 1'b0;
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clk);
    start_tx(CMD_RESET, 1'b1, 1'b1);
    device_serve(1'b1, 0, seen);
    chk("t6b_request_seen", seen, 1);
    wait_idle();

    // Random bytes with random ACK behaviour.
    for (int k = 0; k < 6; k++) begin
      b   = 8'($urandom);
      ack = ($urandom_range(0, 3) != 0);
      start_tx(b, ack, 1'b1);
      device_serve(ack, 0, seen);
      chk("rand_request_seen", seen, 1);
      wait_idle();
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("pulse_count", pulses, pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
